// File: rtl/mux4_pkg.sv
// ---------------------------------------------------------------------------
// mux4_pkg
//
// Shared definitions for the 4:1 round-robin stream combiner and its
// companion 1:4 demux. Both sides import this package so the source index
// carried on `sel` has a single definition.
//
// Contents:
//   SRC_W      - width of a source index (2 bits)
//   NUM_SRC    - number of source channels (4)
//   src_idx_t  - source index type used for `sel` and the priority pointer
//   next_idx() - index of the following channel, wrapping 3 -> 0
// ---------------------------------------------------------------------------
package mux4_pkg;

    localparam int SRC_W   = 2;
    localparam int NUM_SRC = 4;

    typedef logic [SRC_W-1:0] src_idx_t;

    // The index type is exactly log2(NUM_SRC) bits wide, so the plain
    // increment wraps from 3 back to 0 on its own.
    function automatic src_idx_t next_idx(input src_idx_t idx);
        return idx + src_idx_t'(1);
    endfunction

endpackage

// File: rtl/mux_four_to_one_rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
//
// Combinational round-robin grant generator for four requesters. The search
// starts at the priority pointer and moves upward, wrapping 3 -> 0. The
// first asserted request found wins.
//
// Ports:
//   req_i   - request vector, one bit per source
//   ptr_i   - source index with the highest priority this cycle
//   gnt_o   - one-hot grant (all zero when nobody requests)
//   idx_o   - encoded index of the granted source (0 when no grant)
//   any_o   - high when some source is granted
// ---------------------------------------------------------------------------
module rr_arb4
    import mux4_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    input  src_idx_t           ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output src_idx_t           idx_o,
    output logic               any_o
);

    // Walk the four candidates in priority order, beginning at the pointer.
    // Once a winner is found, later candidates are ignored, so the result
    // is always one-hot or zero.
    always_comb begin
        src_idx_t cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = ptr_i;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = ptr_i + src_idx_t'(k);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_four_to_one_rr.sv
// ---------------------------------------------------------------------------
// mux_four_to_one_rr
//
// Four-to-one stream combiner with round-robin arbitration. Four independent
// valid/ready sources are merged into one registered output channel. Each
// output beat carries the index of its source on `sel` so a downstream 1:4
// demux can steer it back out. A single output register gives one-cycle
// latency and full throughput while the sink is ready.
//
// Optional feature (macro MUX4_LOCK_EN):
//   Packet lock. A grant given to a beat whose last flag is low stays locked
//   to that channel until its last beat is transferred. The lin*/lout ports
//   exist only with this macro defined.
//
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   din0..din3     - source data (WIDTH bits each)
//   vin0..vin3     - source valid
//   rdy0..rdy3     - source ready (combinational, no path from data)
//   lin0..lin3     - source last flag            (MUX4_LOCK_EN only)
//   dout           - merged data, registered
//   sel            - source index of dout, registered
//   vout           - dout/sel valid, registered
//   lout           - last flag of dout, registered (MUX4_LOCK_EN only)
//   rdy_out        - downstream ready
// ---------------------------------------------------------------------------
module mux_four_to_one_rr
    import mux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic             vin0,
    input  logic             vin1,
    input  logic             vin2,
    input  logic             vin3,
    output logic             rdy0,
    output logic             rdy1,
    output logic             rdy2,
    output logic             rdy3,
`ifdef MUX4_LOCK_EN
    input  logic             lin0,
    input  logic             lin1,
    input  logic             lin2,
    input  logic             lin3,
    output logic             lout,
`endif
    output logic [WIDTH-1:0] dout,
    output src_idx_t         sel,
    output logic             vout,
    input  logic             rdy_out
);

    logic [WIDTH-1:0]   dinArr [NUM_SRC];
    logic [NUM_SRC-1:0] vinVec;
    logic [NUM_SRC-1:0] reqEff;
    logic [NUM_SRC-1:0] gntVec;
    src_idx_t           gntIdx;
    logic               gntAny;
    logic               outFree;
    logic               srcXfer;

    logic [WIDTH-1:0]   dout_q, dout_d;
    src_idx_t           sel_q,  sel_d;
    logic               vout_q, vout_d;
    src_idx_t           ptr_q,  ptr_d;

`ifdef MUX4_LOCK_EN
    logic [NUM_SRC-1:0] linVec;
    logic               lout_q,    lout_d;
    logic               lock_q,    lock_d;
    src_idx_t           lockIdx_q, lockIdx_d;
`endif

    // Gather the scalar source ports into vectors so the rest of the logic
    // can index them by source number.
    always_comb begin
        dinArr[0] = din0;
        dinArr[1] = din1;
        dinArr[2] = din2;
        dinArr[3] = din3;
        vinVec    = {vin3, vin2, vin1, vin0};
    end

`ifdef MUX4_LOCK_EN
    assign linVec = {lin3, lin2, lin1, lin0};

    // While a packet is in flight only the locked channel may compete. If it
    // drops valid mid-packet nobody is granted, which keeps the packet
    // contiguous on the output.
    always_comb begin
        reqEff = vinVec;
        if (lock_q) begin
            reqEff = vinVec & (NUM_SRC'(1) << lockIdx_q);
        end
    end
`else
    assign reqEff = vinVec;
`endif

    rr_arb4 u_arb (
        .req_i (reqEff),
        .ptr_i (ptr_q),
        .gnt_o (gntVec),
        .idx_o (gntIdx),
        .any_o (gntAny)
    );

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this cycle. Ready only depends on valids, the
    // pointer and the output stage, never on source data.
    assign outFree = !vout_q || rdy_out;
    assign srcXfer = gntAny && outFree;

    assign {rdy3, rdy2, rdy1, rdy0} = gntVec & {NUM_SRC{outFree}};

    // Next-state for the output stage and pointer. A source transfer loads
    // the stage (replacing a departing beat with no bubble). A departing beat
    // with nothing to replace it just clears valid; data and index hold.
    // Source data is only looked at on the cycle that channel transfers.
    always_comb begin
        dout_d = dout_q;
        sel_d  = sel_q;
        vout_d = vout_q;
        ptr_d  = ptr_q;
`ifdef MUX4_LOCK_EN
        lout_d    = lout_q;
        lock_d    = lock_q;
        lockIdx_d = lockIdx_q;
`endif
        if (srcXfer) begin
            dout_d = dinArr[gntIdx];
            sel_d  = gntIdx;
            vout_d = 1'b1;
`ifdef MUX4_LOCK_EN
            lout_d = linVec[gntIdx];
            if (linVec[gntIdx]) begin
                // End of packet: release the lock and let the next channel
                // in line have priority.
                ptr_d  = next_idx(gntIdx);
                lock_d = 1'b0;
            end else begin
                lock_d    = 1'b1;
                lockIdx_d = gntIdx;
            end
`else
            ptr_d = next_idx(gntIdx);
`endif
        end else if (rdy_out) begin
            vout_d = 1'b0;
        end
    end

    // State registers. Reset drops any buffered beat, returns first priority
    // to channel 0 and clears the packet lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            sel_q  <= '0;
            vout_q <= 1'b0;
            ptr_q  <= '0;
`ifdef MUX4_LOCK_EN
            lout_q    <= 1'b0;
            lock_q    <= 1'b0;
            lockIdx_q <= '0;
`endif
        end else begin
            dout_q <= dout_d;
            sel_q  <= sel_d;
            vout_q <= vout_d;
            ptr_q  <= ptr_d;
`ifdef MUX4_LOCK_EN
            lout_q    <= lout_d;
            lock_q    <= lock_d;
            lockIdx_q <= lockIdx_d;
`endif
        end
    end

    assign dout = dout_q;
    assign sel  = sel_q;
    assign vout = vout_q;
`ifdef MUX4_LOCK_EN
    assign lout = lout_q;
`endif

endmodule

// File: tb/tb_mux_four_to_one_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_four_to_one_rr
//
// Directed bench for the 4:1 round-robin combiner. Inputs change 1 time unit
// after a rising edge; ready is looked at once it settles and registered
// outputs are looked at 1 time unit after the following edge. Packet-lock
// vectors are included when MUX4_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_mux_four_to_one_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din1, din2, din3;
    logic       vin0, vin1, vin2, vin3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic [7:0] dout;
    logic [1:0] sel;
    logic       vout;
    logic       rdy_out;
`ifdef MUX4_LOCK_EN
    logic       lin0, lin1, lin2, lin3;
    logic       lout;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    logic [3:0] rdyVec;
    assign rdyVec = {rdy3, rdy2, rdy1, rdy0};

    always #5 clk = ~clk;

    mux_four_to_one_rr #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .din0    (din0),
        .din1    (din1),
        .din2    (din2),
        .din3    (din3),
        .vin0    (vin0),
        .vin1    (vin1),
        .vin2    (vin2),
        .vin3    (vin3),
        .rdy0    (rdy0),
        .rdy1    (rdy1),
        .rdy2    (rdy2),
        .rdy3    (rdy3),
`ifdef MUX4_LOCK_EN
        .lin0    (lin0),
        .lin1    (lin1),
        .lin2    (lin2),
        .lin3    (lin3),
        .lout    (lout),
`endif
        .dout    (dout),
        .sel     (sel),
        .vout    (vout),
        .rdy_out (rdy_out)
    );

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the valid vector and downstream ready.
    task automatic applyStimulus(input logic [3:0] vinVec, input logic rdyOut);
        {vin3, vin2, vin1, vin0} = vinVec;
        rdy_out = rdyOut;
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        applyStimulus(4'b0000, 1'b0);
`ifdef MUX4_LOCK_EN
        lin0 = 1'b1; lin1 = 1'b1; lin2 = 1'b1; lin3 = 1'b1;
`endif
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state, no requests.
        checkOutput("reset_vout", 32'(vout), 32'h0);
        checkOutput("reset_sel",  32'(sel),  32'h0);
        checkOutput("reset_dout", 32'(dout), 32'h0);
        checkOutput("reset_rdy",  32'(rdyVec), 32'h0);

        // Single source on channel 2.
        din2 = 8'hA5;
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("single_rdy", 32'(rdyVec), 32'h4);
        tick();
        checkOutput("single_vout", 32'(vout), 32'h1);
        checkOutput("single_dout", 32'(dout), 32'hA5);
        checkOutput("single_sel",  32'(sel),  32'h2);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("drain_vout", 32'(vout), 32'h0);
        checkOutput("drain_sel_hold",  32'(sel),  32'h2);
        checkOutput("drain_dout_hold", 32'(dout), 32'hA5);
        // Pointer now at 3: channel 3 beats channel 0.
        applyStimulus(4'b1001, 1'b1);
        #1;
        checkOutput("ptr3_rdy", 32'(rdyVec), 32'h8);
        applyStimulus(4'b0000, 1'b1);

        // All four requesting continuously from a fresh pointer.
        doReset();
        din0 = 8'h10; din1 = 8'h11; din2 = 8'h12; din3 = 8'h13;
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("rr_sel%0d", k),  32'(sel),  32'(k % 4));
            checkOutput($sformatf("rr_dout%0d", k), 32'(dout), 32'(8'h10 + (k % 4)));
            checkOutput($sformatf("rr_vout%0d", k), 32'(vout), 32'h1);
        end

        // Backpressure: stage holds sel=1, pointer at 2.
        applyStimulus(4'b1111, 1'b0);
        #1;
        checkOutput("stall_rdy0", 32'(rdyVec), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("stall_sel%0d", k),  32'(sel),  32'h1);
            checkOutput($sformatf("stall_dout%0d", k), 32'(dout), 32'h11);
            checkOutput($sformatf("stall_vout%0d", k), 32'(vout), 32'h1);
            checkOutput($sformatf("stall_rdy%0d", k),  32'(rdyVec), 32'h0);
        end
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("release_rdy", 32'(rdyVec), 32'h4);
        tick();
        checkOutput("release_sel",  32'(sel),  32'h2);
        checkOutput("release_dout", 32'(dout), 32'h12);

        // Reset while the stage is full and stalled.
        applyStimulus(4'b1111, 1'b0);
        tick();
        checkOutput("prerst_vout", 32'(vout), 32'h1);
        checkOutput("prerst_sel",  32'(sel),  32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_vout", 32'(vout), 32'h0);
        checkOutput("midrst_dout", 32'(dout), 32'h0);
        checkOutput("midrst_sel",  32'(sel),  32'h0);
        applyStimulus(4'b1001, 1'b1);
        #1;
        checkOutput("postrst_rdy", 32'(rdyVec), 32'h1);
        tick();
        checkOutput("postrst_sel0",  32'(sel),  32'h0);
        checkOutput("postrst_dout0", 32'(dout), 32'h10);
        tick();
        checkOutput("postrst_sel3",  32'(sel),  32'h3);
        checkOutput("postrst_dout3", 32'(dout), 32'h13);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("postrst_idle_vout", 32'(vout), 32'h0);

`ifdef MUX4_LOCK_EN
        // Packet lock: move pointer to 1 with a one-beat packet on ch0, then
        // ch1 sends a 3-beat packet while ch0 and ch2 keep requesting.
        doReset();
        din0 = 8'h20; din1 = 8'h30; din2 = 8'h40;
        lin0 = 1'b1; lin1 = 1'b0; lin2 = 1'b1;
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkOutput("lk_pre_sel",  32'(sel),  32'h0);
        checkOutput("lk_pre_lout", 32'(lout), 32'h1);
        applyStimulus(4'b0111, 1'b1);
        #1;
        checkOutput("lk_first_rdy", 32'(rdyVec), 32'h2);
        tick();
        checkOutput("lk_b0_sel",  32'(sel),  32'h1);
        checkOutput("lk_b0_dout", 32'(dout), 32'h30);
        checkOutput("lk_b0_lout", 32'(lout), 32'h0);
        // Locked channel drops valid: no one else may be granted.
        applyStimulus(4'b0101, 1'b1);
        #1;
        checkOutput("lk_gap_rdy", 32'(rdyVec), 32'h0);
        tick();
        checkOutput("lk_gap_vout", 32'(vout), 32'h0);
        din1 = 8'h31;
        applyStimulus(4'b0111, 1'b1);
        tick();
        checkOutput("lk_b1_sel",  32'(sel),  32'h1);
        checkOutput("lk_b1_dout", 32'(dout), 32'h31);
        checkOutput("lk_b1_lout", 32'(lout), 32'h0);
        din1 = 8'h32;
        lin1 = 1'b1;
        tick();
        checkOutput("lk_b2_sel",  32'(sel),  32'h1);
        checkOutput("lk_b2_dout", 32'(dout), 32'h32);
        checkOutput("lk_b2_lout", 32'(lout), 32'h1);
        tick();
        checkOutput("lk_next_sel",  32'(sel),  32'h2);
        checkOutput("lk_next_dout", 32'(dout), 32'h40);
        applyStimulus(4'b0000, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mux_four_to_one_rr.md
# mux_four_to_one_rr

Four-to-one stream combiner with round-robin arbitration: the return path for the 1:4 demux. Four independent valid/ready source channels are merged onto one output channel. Each output beat carries the 2-bit index of the source it came from, so a downstream 1:4 demux can steer it back out. A single registered output stage gives one-cycle latency at full throughput.

## Interface
- `WIDTH`, default 8: data width of every channel.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `din0`..`din3` input, WIDTH each: source data.
- `vin0`..`vin3` input, 1 bit each: source valid.
- `rdy0`..`rdy3` output, 1 bit each: source ready. Combinational from grant and output-stage state.
- `dout` output, WIDTH: merged data, registered.
- `sel` output, 2 bits: source index of `dout`, registered.
- `vout` output, 1 bit: `dout`/`sel` valid, registered.
- `rdy_out` input, 1 bit: downstream ready.
- `lin0`..`lin3` input, 1 bit each: last-beat flag. Present only with `MUX4_LOCK_EN`.
- `lout` output, 1 bit: registered last flag. Present only with `MUX4_LOCK_EN`.

## Operation
- Transfer on any channel = valid && ready in the same cycle.
- Output stage is free when `!vout || rdy_out`.
- Grant selection:
  - Pick one requester among asserted `vinN`, searching upward from priority pointer `ptr` with wrap 3→0.
  - Only the granted channel sees `rdyN=1`, and only while the output stage is free. All other `rdyN` are 0.
  - No requester means no grant and all `rdyN` = 0.
- On a source transfer from channel i: load `dout<=dinI`, `sel<=i`, `vout<=1`, then `ptr<=(i+1) mod 4`.
- Output transfer with no source transfer in the same cycle: `vout<=0`. `dout` and `sel` hold their value.
- Output transfer and source transfer in the same cycle: the new beat replaces the old one, with no bubble.
- `vout=1 && rdy_out=0`: hold the stage. All `rdyN`=0. `dout`/`sel` stay stable.
- Source data must not be sampled unless that channel has a transfer.
- Reset values: `vout=0`, `dout=0`, `sel=0`, `ptr=0` (channel 0 has first priority), and `lout=0` when the macro is enabled.
- Reset mid-operation drops any buffered beat. No partial state survives.

## Timing
- Latency: a beat accepted at edge N is visible on `dout`/`vout` after edge N.
- Throughput: one beat per cycle while `rdy_out=1`.
- Fairness: with all four channels requesting continuously, grants cycle 0,1,2,3,0…. No channel waits more than 3 beats.
- `ptr` changes only on a source transfer. Idle cycles and stall cycles leave it unchanged.
- `rdyN` depends combinationally on `vinM` (all M), `ptr`, `vout` and `rdy_out`. There is no path from `dinN` to any ready.

## Configuration
- Macro `MUX4_LOCK_EN`.
- Defined:
  - Packet lock. Once a channel is granted with its `linN=0`, the grant stays locked to that channel until a beat with `linN=1` is transferred.
  - While locked, other channels get no grant even if the locked channel drops valid.
  - `ptr` advances only on the transfer of a last beat.
  - `lout` carries the beat's last flag.
  - Reset clears the lock.
- Undefined:
  - Arbitration happens on every beat.
  - The `lin*`/`lout` ports and the lock state are absent.

## Structure
- Shared package `mux4_pkg`:
  - `SRC_W=2`, the source-index width.
  - `NUM_SRC=4`.
  - Typedef `src_idx_t` (2 bits), shared with the demux side so both sides use one definition of `sel`.
- One sub-module, `rr_arb4`, a combinational round-robin grant generator:
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot grant, encoded index, any-grant.
- The top level holds `ptr`, the output register and (with the macro) the lock state.

## Test plan
- Reset, then all `vin`=0 → `vout=0`, `sel=0`, `dout=0`, all `rdyN`=0.
- Single source: `vin2=1`, `din2=8'hA5`, `rdy_out=1` → `rdy2=1`. Next cycle `vout=1`, `dout=8'hA5`, `sel=2`. `ptr` moves to 3.
- All four requesting continuously with `dinN=N+8'h10`, `rdy_out=1` → output `sel` sequence 0,1,2,3,0,1 back-to-back, no idle cycles, `dout` matching.
- Backpressure: `rdy_out=0` for 3 cycles with `vout=1` → `dout`/`sel` stable, all `rdyN`=0. Release → the next grant resumes from the stalled `ptr`.
- Reset asserted while `vout=1 && rdy_out=0` → next cycle `vout=0` and `ptr=0`. A subsequent request from ch3 and ch0 together grants ch0 first.
- With `MUX4_LOCK_EN`: ch1 sends a 3-beat packet (`lin1`=0,0,1) while ch0 and ch2 request → three consecutive `sel=1` beats, `lout` set only on the third, then ch2 is granted.
